// File: rtl/imm_gen_pipe_if.sv
// Decode-to-execute immediate handshake bundle.
// Master drives instructions and consumes immediates; slave is the generator.
interface imm_gen_pipe_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instr;
    logic [2:0]      imm_src;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] imm;
    logic [2:0]      imm_fmt;
    logic            illegal;

    modport master (
        output in_valid, instr, imm_src, out_ready,
        input  in_ready, out_valid, imm, imm_fmt, illegal
    );

    modport slave (
        input  in_valid, instr, imm_src, out_ready,
        output in_ready, out_valid, imm, imm_fmt, illegal
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// Two-entry FIFO whose head always lives in slot0, so the head is a plain register.
// Latency: push visible at the head one cycle later when empty.
// Backpressure: pushes beyond two entries and pops of an empty buffer are ignored.
module imm_gen_fifo2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic [1:0]       count
);
    logic [WIDTH-1:0] slot0;
    logic [WIDTH-1:0] slot1;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push && (count != 2'd2);
    assign do_pop   = pop  && (count != 2'd0);
    assign head_dat = slot0;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 2'd0;
            slot0 <= '0;
            slot1 <= '0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (count == 2'd0) slot0 <= push_dat;
                    else               slot1 <= push_dat;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    slot0 <= slot1;
                    count <= count - 2'd1;
                end
                // Simultaneous push/pop only happens at count==1, so the new entry becomes head.
                2'b11: slot0 <= push_dat;
                default: ;
            endcase
        end
    end
endmodule

// RISC-V immediate generator: decode/extend at accept, hold result in a 2-entry buffer.
// Latency: 1 cycle from accept to out_valid; 1 result/cycle with concurrent push and pop.
// Backpressure: in_ready depends only on buffer occupancy; head outputs hold while stalled.
module imm_gen_pipe #(
    parameter int XLEN        = 32,
    parameter int AUTO_DECODE = 0,
    parameter int DEPTH       = 2
) (
    input logic           clk,
    input logic           rst,
    imm_gen_pipe_if.slave bus
);
    localparam logic [2:0] FMT_I   = 3'b000;
    localparam logic [2:0] FMT_S   = 3'b001;
    localparam logic [2:0] FMT_B   = 3'b010;
    localparam logic [2:0] FMT_U   = 3'b011;
    localparam logic [2:0] FMT_J   = 3'b100;
    localparam logic [2:0] FMT_SH  = 3'b101;
    localparam logic [2:0] FMT_ILL = 3'b111;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            ill;
    } ent_t;

    if (DEPTH != 2 || (XLEN != 32 && XLEN != 64)) begin : g_bad_param
        $error("imm_gen_pipe: DEPTH must be 2 and XLEN must be 32 or 64");
    end

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            is_shift;
    logic            s;
    logic [2:0]      fmt_auto;
    logic [2:0]      fmt_res;
    logic [XLEN-1:0] imm_new;
    ent_t            new_ent;
    ent_t            head_ent;
    logic [1:0]      count;

    assign opcode   = bus.instr[6:0];
    assign funct3   = bus.instr[14:12];
    assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
    assign s        = bus.instr[31];

    always_comb begin
        fmt_auto = FMT_ILL;
        case (opcode)
            7'b0010011:             fmt_auto = is_shift ? FMT_SH : FMT_I;
            7'b0000011, 7'b1100111: fmt_auto = FMT_I;
            // Word-sized ALU immediates only exist on RV64.
            7'b0011011: if (XLEN == 64) fmt_auto = is_shift ? FMT_SH : FMT_I;
            7'b0100011:             fmt_auto = FMT_S;
            7'b1100011:             fmt_auto = FMT_B;
            7'b0110111, 7'b0010111: fmt_auto = FMT_U;
            7'b1101111:             fmt_auto = FMT_J;
            default:                fmt_auto = FMT_ILL;
        endcase
    end

    assign fmt_res = (AUTO_DECODE != 0) ? fmt_auto : bus.imm_src;

    always_comb begin
        imm_new = '0;
        case (fmt_res)
            FMT_I:  imm_new = {{(XLEN-12){s}}, bus.instr[31:20]};
            FMT_S:  imm_new = {{(XLEN-12){s}}, bus.instr[31:25], bus.instr[11:7]};
            FMT_B:  imm_new = {{(XLEN-12){s}}, bus.instr[7], bus.instr[30:25],
                               bus.instr[11:8], 1'b0};
            FMT_U:  imm_new = {{(XLEN-31){s}}, bus.instr[30:12], 12'b0};
            FMT_J:  imm_new = {{(XLEN-20){s}}, bus.instr[19:12], bus.instr[20],
                               bus.instr[30:21], 1'b0};
            FMT_SH: imm_new = {{(XLEN-6){1'b0}}, (XLEN == 64) ? bus.instr[25] : 1'b0,
                               bus.instr[24:20]};
            default: imm_new = '0;
        endcase
    end

    assign new_ent.imm = imm_new;
    assign new_ent.fmt = fmt_res;
    assign new_ent.ill = fmt_res[2] & fmt_res[1];

    imm_gen_fifo2 #(
        .WIDTH($bits(ent_t))
    ) u_buf (
        .clk      (clk),
        .rst      (rst),
        .push     (bus.in_valid && bus.in_ready),
        .push_dat (new_ent),
        .pop      (bus.out_valid && bus.out_ready),
        .head_dat (head_ent),
        .count    (count)
    );

    assign bus.in_ready  = (count < 2'd2);
    assign bus.out_valid = (count != 2'd0);
    assign bus.imm       = head_ent.imm;
    assign bus.imm_fmt   = head_ent.fmt;
    assign bus.illegal   = head_ent.ill;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: three instances (32/manual, 32/auto, 64/auto) against an
// arithmetic reference model and a per-instance expected-result queue.
module tb_imm_gen_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(32)) b0 ();
    imm_gen_pipe_if #(.XLEN(32)) b1 ();
    imm_gen_pipe_if #(.XLEN(64)) b2 ();

    imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(0), .DEPTH(2)) u0 (.clk(clk), .rst(rst), .bus(b0.slave));
    imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(1), .DEPTH(2)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));
    imm_gen_pipe #(.XLEN(64), .AUTO_DECODE(1), .DEPTH(2)) u2 (.clk(clk), .rst(rst), .bus(b2.slave));

    typedef struct {
        int          id;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } exp_t;

    exp_t sb[$];

    task automatic cmp(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic longint bits(logic [31:0] ins, int hi, int lo);
        longint one = 1;
        return (longint'({32'b0, ins}) >> lo) & ((one << (hi - lo + 1)) - 1);
    endfunction

    function automatic longint sext(longint v, int n);
        longint one = 1;
        return (v >= (one << (n - 1))) ? v - (one << n) : v;
    endfunction

    function automatic exp_t model(int id, logic [31:0] ins, logic [2:0] src);
        exp_t   e;
        int     xlen;
        int     op;
        int     f3;
        int     f;
        longint v;
        xlen = (id == 2) ? 64 : 32;
        op   = int'(ins[6:0]);
        f3   = int'(ins[14:12]);
        if (id == 0) f = int'(src);
        else begin
            f = 7;
            if (op == 'h13 || (op == 'h1B && xlen == 64)) f = (f3 == 1 || f3 == 5) ? 5 : 0;
            else if (op == 'h03 || op == 'h67) f = 0;
            else if (op == 'h23) f = 1;
            else if (op == 'h63) f = 2;
            else if (op == 'h37 || op == 'h17) f = 3;
            else if (op == 'h6F) f = 4;
        end
        case (f)
            0: v = sext(bits(ins, 31, 20), 12);
            1: v = sext(bits(ins, 31, 25) * 32 + bits(ins, 11, 7), 12);
            2: v = sext(bits(ins, 31, 31) * 4096 + bits(ins, 7, 7) * 2048
                        + bits(ins, 30, 25) * 32 + bits(ins, 11, 8) * 2, 13);
            3: v = sext(bits(ins, 31, 12) * 4096, 32);
            4: v = sext(bits(ins, 31, 31) * 1048576 + bits(ins, 19, 12) * 4096
                        + bits(ins, 20, 20) * 2048 + bits(ins, 30, 21) * 2, 21);
            5: v = (xlen == 64) ? bits(ins, 25, 20) : bits(ins, 24, 20);
            default: v = 0;
        endcase
        e.id  = id;
        e.fmt = 3'(f);
        e.ill = (f >= 6);
        e.imm = (xlen == 32) ? (64'(v) & 64'hFFFF_FFFF) : 64'(v);
        return e;
    endfunction

    function automatic logic rdy(int id);
        return (id == 0) ? b0.in_ready : (id == 1) ? b1.in_ready : b2.in_ready;
    endfunction

    function automatic logic ovf(int id);
        return (id == 0) ? b0.out_valid : (id == 1) ? b1.out_valid : b2.out_valid;
    endfunction

    function automatic logic [63:0] immf(int id);
        return (id == 0) ? 64'(b0.imm) : (id == 1) ? 64'(b1.imm) : b2.imm;
    endfunction

    function automatic logic [2:0] fmtf(int id);
        return (id == 0) ? b0.imm_fmt : (id == 1) ? b1.imm_fmt : b2.imm_fmt;
    endfunction

    function automatic logic illf(int id);
        return (id == 0) ? b0.illegal : (id == 1) ? b1.illegal : b2.illegal;
    endfunction

    task automatic observe(int id, logic iv, logic ir, logic [31:0] ins, logic [2:0] src,
                           logic ov, logic orr, logic [63:0] imm, logic [2:0] fmt, logic ill);
        int n;
        int head;
        n = 0;
        head = -1;
        foreach (sb[i]) if (sb[i].id == id) begin
            if (head < 0) head = i;
            n++;
        end
        cmp($sformatf("in_ready_u%0d", id), 64'(ir), 64'(n < 2));
        cmp($sformatf("out_valid_u%0d", id), 64'(ov), 64'(n > 0));
        if (ov && head >= 0) begin
            cmp($sformatf("imm_u%0d", id), imm, sb[head].imm);
            cmp($sformatf("fmt_u%0d", id), 64'(fmt), 64'(sb[head].fmt));
            cmp($sformatf("ill_u%0d", id), 64'(ill), 64'(sb[head].ill));
            if (orr) sb.delete(head);
        end
        if (iv && ir) sb.push_back(model(id, ins, src));
    endtask

    // Single compare process: every cycle, every instance, against the model queue.
    always @(negedge clk) begin
        if (rst) sb.delete();
        else begin
            observe(0, b0.in_valid, b0.in_ready, b0.instr, b0.imm_src, b0.out_valid,
                    b0.out_ready, 64'(b0.imm), b0.imm_fmt, b0.illegal);
            observe(1, b1.in_valid, b1.in_ready, b1.instr, b1.imm_src, b1.out_valid,
                    b1.out_ready, 64'(b1.imm), b1.imm_fmt, b1.illegal);
            observe(2, b2.in_valid, b2.in_ready, b2.instr, b2.imm_src, b2.out_valid,
                    b2.out_ready, b2.imm, b2.imm_fmt, b2.illegal);
        end
    end

    task automatic set_in(int id, logic v, logic [31:0] ins, logic [2:0] src);
        case (id)
            0: begin b0.in_valid = v; b0.instr = ins; b0.imm_src = src; end
            1: begin b1.in_valid = v; b1.instr = ins; b1.imm_src = src; end
            default: begin b2.in_valid = v; b2.instr = ins; b2.imm_src = src; end
        endcase
    endtask

    // Caller is aligned at posedge+#1; returns aligned at posedge+#1 after the accepting edge.
    task automatic push(int id, logic [31:0] ins, logic [2:0] src);
        bit acc;
        acc = 1'b0;
        set_in(id, 1'b1, ins, src);
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            acc = rdy(id);
            @(posedge clk);
            #1;
        end
        set_in(id, 1'b0, ins, src);
        cmp($sformatf("push_accepted_u%0d", id), 64'(acc), 64'd1);
    endtask

    task automatic send_chk(int id, logic [31:0] ins, logic [2:0] src,
                            logic [63:0] eimm, logic [2:0] efmt, logic eill);
        push(id, ins, src);
        @(negedge clk);
        cmp($sformatf("lit_valid_u%0d_%h", id, ins), 64'(ovf(id)), 64'd1);
        cmp($sformatf("lit_imm_u%0d_%h", id, ins), immf(id), eimm);
        cmp($sformatf("lit_fmt_u%0d_%h", id, ins), 64'(fmtf(id)), 64'(efmt));
        cmp($sformatf("lit_ill_u%0d_%h", id, ins), 64'(illf(id)), 64'(eill));
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t p;
        set_in(0, 1'b0, 32'h0, 3'b0);
        set_in(1, 1'b0, 32'h0, 3'b0);
        set_in(2, 1'b0, 32'h0, 3'b0);
        b0.out_ready = 1'b1;
        b1.out_ready = 1'b1;
        b2.out_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        for (int id = 0; id < 3; id++) begin
            cmp($sformatf("rst_valid_u%0d", id), 64'(ovf(id)), 64'd0);
            cmp($sformatf("rst_ready_u%0d", id), 64'(rdy(id)), 64'd1);
            cmp($sformatf("rst_imm_u%0d", id), immf(id), 64'd0);
            cmp($sformatf("rst_fmt_u%0d", id), 64'(fmtf(id)), 64'd0);
            cmp($sformatf("rst_ill_u%0d", id), 64'(illf(id)), 64'd0);
        end
        @(posedge clk);
        #1;

        p = model(0, 32'hFFF0_0093, 3'b000);
        cmp("pin_model_I", p.imm, 64'hFFFF_FFFF);
        p = model(0, 32'hFE00_0CE3, 3'b010);
        cmp("pin_model_B", p.imm, 64'hFFFF_FFF8);
        p = model(1, 32'h40F0_D093, 3'b000);
        cmp("pin_model_shamt", p.imm, 64'hF);
        cmp("pin_model_shamt_fmt", 64'(p.fmt), 64'd5);
        p = model(2, 32'h8000_00B7, 3'b000);
        cmp("pin_model_U64", p.imm, 64'hFFFF_FFFF_8000_0000);

        send_chk(0, 32'hFFF0_0093, 3'b000, 64'hFFFF_FFFF, 3'b000, 1'b0);
        send_chk(0, 32'hFE20_AE23, 3'b001, 64'hFFFF_FFFC, 3'b001, 1'b0);
        send_chk(0, 32'hFE00_0CE3, 3'b010, 64'hFFFF_FFF8, 3'b010, 1'b0);

        // U then J back-to-back: J must follow U with no bubble.
        push(0, 32'h1234_50B7, 3'b011);
        fork
            push(0, 32'h0010_00EF, 3'b100);
            begin
                @(negedge clk);
                cmp("b2b_U_imm", immf(0), 64'h1234_5000);
                @(negedge clk);
                cmp("b2b_J_valid", 64'(ovf(0)), 64'd1);
                cmp("b2b_J_imm", immf(0), 64'h0000_0800);
            end
        join
        @(posedge clk);
        #1;

        // Back-pressure: A,B fill the buffer, C waits at the input until a pop.
        b0.out_ready = 1'b0;
        fork
            begin
                push(0, 32'h0050_0113, 3'b000);
                push(0, 32'h0011_2423, 3'b001);
                push(0, 32'h0020_8463, 3'b010);
            end
            begin
                repeat (4) @(negedge clk);
                cmp("bp_ready_low", 64'(b0.in_ready), 64'd0);
                cmp("bp_head_A", immf(0), 64'd5);
                @(posedge clk);
                #1 b0.out_ready = 1'b1;
            end
        join
        repeat (4) @(posedge clk);
        #1;

        send_chk(0, 32'h1234_5678, 3'b111, 64'd0, 3'b111, 1'b1);
        send_chk(0, 32'h1234_5678, 3'b110, 64'd0, 3'b110, 1'b1);
        send_chk(1, 32'h40F0_D093, 3'b000, 64'h0000_000F, 3'b101, 1'b0);
        send_chk(1, 32'h0000_0000, 3'b000, 64'd0, 3'b111, 1'b1);
        send_chk(1, 32'h0000_101B, 3'b000, 64'd0, 3'b111, 1'b1);
        send_chk(2, 32'hFFF0_0093, 3'b000, 64'hFFFF_FFFF_FFFF_FFFF, 3'b000, 1'b0);
        send_chk(2, 32'h8000_00B7, 3'b000, 64'hFFFF_FFFF_8000_0000, 3'b011, 1'b0);
        send_chk(2, 32'h03F0_9093, 3'b000, 64'h0000_0000_0000_003F, 3'b101, 1'b0);
        send_chk(2, 32'h8000_006F, 3'b000, 64'hFFFF_FFFF_FFF0_0000, 3'b100, 1'b0);
        send_chk(2, 32'hFFF0_009B, 3'b000, 64'hFFFF_FFFF_FFFF_FFFF, 3'b000, 1'b0);

        // Reset with a full buffer discards both held entries.
        b0.out_ready = 1'b0;
        push(0, 32'h0010_0093, 3'b000);
        push(0, 32'h0020_0093, 3'b000);
        @(negedge clk);
        cmp("full_ready_low", 64'(b0.in_ready), 64'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        cmp("midrst_valid", 64'(b0.out_valid), 64'd0);
        cmp("midrst_ready", 64'(b0.in_ready), 64'd1);
        cmp("midrst_imm", immf(0), 64'd0);
        @(posedge clk);
        #1 b0.out_ready = 1'b1;
        send_chk(0, 32'h0070_0093, 3'b000, 64'd7, 3'b000, 1'b0);

        repeat (5) @(posedge clk);
        #1;
        cmp("queue_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
